// File: rtl/unrot_pkg.sv
// unrot_pkg: shared constants and helpers for the pipelined inverse rotator.
// Bit 0 of every word is the leftmost (most significant) bit.
package unrot_pkg;

  localparam int DEF_N      = 2048;
  localparam int DEF_LOG2_N = 11;

  // Left-rotate distance applied by stage s of an n-bit rotator.
  function automatic int stage_shift(input int n, input int s);
    return n >> (s + 1);
  endfunction

  // Reference left rotation: result[j] = word[(j + amount) mod n].
  // Narrower words (n < DEF_N) occupy positions 0..n-1; the rest read as 0.
  function automatic logic [0:DEF_N-1] rotl(input logic [0:DEF_N-1] word,
                                            input int amount,
                                            input int n = DEF_N);
    logic [0:DEF_N-1] r;
    r = {DEF_N{1'b0}};
    for (int j = 0; j < DEF_N; j++) begin
      if (j < n) begin
        r[j] = word[(j + amount) % n];
      end else begin
        r[j] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/unrot_stage.sv
// unrot_stage: one conditional left-rotate stage of unrot_pipe, optionally
// followed by a valid/data/k register slot (REG = 1). With REG = 0 the stage
// is purely combinational and the handshake passes straight through.
module unrot_stage
  import unrot_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int log2_N       = DEF_LOG2_N,
  parameter int stage_number = 0,
  parameter int REG          = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            up_valid,
  output logic            up_ready,
  input  logic [0:N-1]    up_bits,
  input  logic [0:log2_N-1] up_k,
  output logic            down_valid,
  input  logic            down_ready,
  output logic [0:N-1]    down_bits,
  output logic [0:log2_N-1] down_k
);

  localparam int SH = stage_shift(N, stage_number);

  logic [0:N-1] rot_bits;

  // Rotate left by SH when this stage's k bit is set, else pass through.
  assign rot_bits = up_k[stage_number] ? {up_bits[SH:N-1], up_bits[0:SH-1]}
                                       : up_bits;

  if (REG == 1) begin : g_reg
    logic              slot_valid;
    logic [0:N-1]      slot_bits;
    logic [0:log2_N-1] slot_k;

    // An empty slot always accepts, so bubbles collapse under a stall.
    assign up_ready = !slot_valid || down_ready;

    // Slot register: capture on upstream transfer, empty on downstream transfer.
    always_ff @(posedge clk) begin
      if (rst) begin
        slot_valid <= 1'b0;
        slot_bits  <= {N{1'b0}};
        slot_k     <= {log2_N{1'b0}};
      end else if (up_valid && up_ready) begin
        slot_valid <= 1'b1;
        slot_bits  <= rot_bits;
        slot_k     <= up_k;
      end else if (down_ready) begin
        slot_valid <= 1'b0;
      end
    end

    assign down_valid = slot_valid;
    assign down_bits  = slot_bits;
    assign down_k     = slot_k;
  end else begin : g_comb
    assign up_ready   = down_ready;
    assign down_valid = up_valid;
    assign down_bits  = rot_bits;
    assign down_k     = up_k;
  end

endmodule

// File: rtl/unrot_pipe.sv
// unrot_pipe: pipelined left rotator that undoes the datapath's right
// rotation. Stage s rotates by N >> (s+1) under in_k[s]; k rides along to
// out_k. Outputs come straight from the last slot's registers.
// Build option UNROT_HALF_PIPE_EN: register only after odd stages and the
// last stage, giving ceil(log2_N/2) cycles of latency and capacity.
module unrot_pipe
  import unrot_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int log2_N = DEF_LOG2_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:N-1]      in_bits,
  input  logic [0:log2_N-1] in_k,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:N-1]      out_bits,
  output logic [0:log2_N-1] out_k
);

  // Index s is the link feeding stage s; index log2_N is the output link.
  logic              vld  [0:log2_N];
  logic              rdy  [0:log2_N];
  logic [0:N-1]      bits [0:log2_N];
  logic [0:log2_N-1] kk   [0:log2_N];

  assign vld[0]       = in_valid;
  assign bits[0]      = in_bits;
  assign kk[0]        = in_k;
  assign rdy[log2_N]  = out_ready;

  // No acceptance is advertised while reset is held.
  assign in_ready = rdy[0] && !rst;

  for (genvar s = 0; s < log2_N; s++) begin : g_stage
`ifdef UNROT_HALF_PIPE_EN
    localparam int STAGE_REG = (((s % 2) == 1) || (s == log2_N - 1)) ? 1 : 0;
`else
    localparam int STAGE_REG = 1;
`endif
    unrot_stage #(
      .N(N),
      .log2_N(log2_N),
      .stage_number(s),
      .REG(STAGE_REG)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .up_valid(vld[s]),
      .up_ready(rdy[s]),
      .up_bits(bits[s]),
      .up_k(kk[s]),
      .down_valid(vld[s+1]),
      .down_ready(rdy[s+1]),
      .down_bits(bits[s+1]),
      .down_k(kk[s+1])
    );
  end

  assign out_valid = vld[log2_N];
  assign out_bits  = bits[log2_N];
  assign out_k     = kk[log2_N];

endmodule

// File: tb/tb_unrot_pipe.sv
// tb_unrot_pipe: scoreboard bench for unrot_pipe at N=16 and N=2048.
// Drivers push expected results when a transfer is offered and accepted;
// independent monitors pop and compare whenever an output transfer occurs.
module tb_unrot_pipe;
  import unrot_pkg::*;

`ifdef UNROT_HALF_PIPE_EN
  localparam int LAT16 = 2;
  localparam int LAT2K = 6;
`else
  localparam int LAT16 = 4;
  localparam int LAT2K = 11;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic        rst16, in_valid16, in_ready16, out_valid16, out_ready16;
  logic [0:15] in_bits16, out_bits16;
  logic [0:3]  in_k16, out_k16;

  logic          rst2k, in_valid2k, in_ready2k, out_valid2k, out_ready2k;
  logic [0:2047] in_bits2k, out_bits2k;
  logic [0:10]   in_k2k, out_k2k;

  unrot_pipe #(.N(16), .log2_N(4)) dut16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_bits(in_bits16), .in_k(in_k16), .out_valid(out_valid16),
    .out_ready(out_ready16), .out_bits(out_bits16), .out_k(out_k16));

  unrot_pipe #(.N(2048), .log2_N(11)) dut2k (
    .clk(clk), .rst(rst2k), .in_valid(in_valid2k), .in_ready(in_ready2k),
    .in_bits(in_bits2k), .in_k(in_k2k), .out_valid(out_valid2k),
    .out_ready(out_ready2k), .out_bits(out_bits2k), .out_k(out_k2k));

  typedef struct { logic [0:15] bits; logic [0:3] k; int issue; bit lat; } e16_t;
  typedef struct { logic [0:2047] bits; logic [0:10] k; int issue; bit lat; } e2k_t;
  e16_t q16[$];
  e2k_t q2k[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_out16 = 0;

  task automatic check(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [0:15] ref16(input logic [0:15] b, input int k);
    logic [0:DEF_N-1] t;
    t = rotl({b, {(DEF_N-16){1'b0}}}, k, 16);
    return t[0:15];
  endfunction

  // Combinational right rotator used upstream in the datapath.
  function automatic logic [0:2047] rotr2k(input logic [0:2047] w, input int k);
    logic [0:2047] r;
    for (int j = 0; j < 2048; j++) r[(j + k) % 2048] = w[j];
    return r;
  endfunction

  function automatic logic [0:2047] rand_word();
    logic [0:2047] r;
    for (int i = 0; i < 64; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor for the 16-bit pipe.
  always @(negedge clk) begin : mon16
    e16_t e;
    if (out_valid16 && out_ready16) begin
      cnt_out16++;
      if (q16.size() == 0) begin
        check("out16_unexpected", 1'b0, 64'(out_bits16), 64'h0);
      end else begin
        e = q16.pop_front();
        check("out16_bits", out_bits16 === e.bits, 64'(out_bits16), 64'(e.bits));
        check("out16_k", out_k16 === e.k, 64'(out_k16), 64'(e.k));
        if (e.lat) check("lat16", (cycle - e.issue) == LAT16,
                         64'(cycle - e.issue), 64'(LAT16));
      end
    end
  end

  // Monitor for the 2048-bit pipe.
  always @(negedge clk) begin : mon2k
    e2k_t e;
    if (out_valid2k && out_ready2k) begin
      if (q2k.size() == 0) begin
        check("out2k_unexpected", 1'b0, out_bits2k[0:63], 64'h0);
      end else begin
        e = q2k.pop_front();
        check("out2k_bits", out_bits2k === e.bits, out_bits2k[0:63], e.bits[0:63]);
        check("out2k_k", out_k2k === e.k, 64'(out_k2k), 64'(e.k));
        if (e.lat) check("lat2k", (cycle - e.issue) == LAT2K,
                         64'(cycle - e.issue), 64'(LAT2K));
      end
    end
  end

  task automatic send16(input logic [0:15] b, input logic [0:3] k,
                        input logic [0:15] exp, input bit lat, output int waited);
    e16_t e;
    waited = 0;
    in_valid16 = 1'b1; in_bits16 = b; in_k16 = k;
    @(negedge clk);
    while (!in_ready16 && waited < 200) begin @(negedge clk); waited++; end
    if (!in_ready16) begin
      check("send16_timeout", 1'b0, 64'(waited), 64'h0);
    end else begin
      e.bits = exp; e.k = k; e.issue = cycle; e.lat = lat && (waited == 0);
      q16.push_back(e);
    end
    @(posedge clk); #1;
    in_valid16 = 1'b0;
  endtask

  task automatic send2k(input logic [0:2047] b, input logic [0:10] k,
                        input logic [0:2047] exp, input bit lat);
    e2k_t e;
    int waited = 0;
    in_valid2k = 1'b1; in_bits2k = b; in_k2k = k;
    @(negedge clk);
    while (!in_ready2k && waited < 200) begin @(negedge clk); waited++; end
    if (!in_ready2k) begin
      check("send2k_timeout", 1'b0, 64'(waited), 64'h0);
    end else begin
      e.bits = exp; e.k = k; e.issue = cycle; e.lat = lat && (waited == 0);
      q2k.push_back(e);
    end
    @(posedge clk); #1;
    in_valid2k = 1'b0;
  endtask

  task automatic drain16();
    int w = 0;
    while (q16.size() != 0 && w < 100) begin @(negedge clk); w++; end
    check("drain16", q16.size() == 0, 64'(q16.size()), 64'h0);
    @(posedge clk); #1;
  endtask

  task automatic drain2k();
    int w = 0;
    while (q2k.size() != 0 && w < 100) begin @(negedge clk); w++; end
    check("drain2k", q2k.size() == 0, 64'(q2k.size()), 64'h0);
    @(posedge clk); #1;
  endtask

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [0:15] dir_b [0:4] = '{16'h8000, 16'h1234, 16'hA5C3, 16'h8001, 16'h00FF};
  logic [0:3]  dir_k [0:4] = '{4'd1, 4'd4, 4'd0, 4'd15, 4'd8};
  logic [0:15] dir_e [0:4] = '{16'h0001, 16'h2341, 16'hA5C3, 16'hC000, 16'hFF00};

  initial begin : stim
    int w;
    int acc;
    int outs_before;
    bit hold_seen;
    logic [0:15] hold_bits;
    logic [0:3]  hold_k;
    logic [0:15] bp_b [0:7];
    logic [0:3]  bp_k [0:7];
    logic [0:2047] wd;
    logic [0:10]   kd;

    rst16 = 1'b1; rst2k = 1'b1;
    in_valid16 = 1'b0; in_bits16 = 16'h0; in_k16 = 4'd0; out_ready16 = 1'b1;
    in_valid2k = 1'b0; in_bits2k = {2048{1'b0}}; in_k2k = 11'd0; out_ready2k = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_in_ready16", in_ready16 === 1'b0, 64'(in_ready16), 64'h0);
    check("rst_in_ready2k", in_ready2k === 1'b0, 64'(in_ready2k), 64'h0);
    @(posedge clk); #1;
    rst16 = 1'b0; rst2k = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid16", out_valid16 === 1'b0, 64'(out_valid16), 64'h0);
    check("post_rst_out_bits16", out_bits16 === 16'h0, 64'(out_bits16), 64'h0);
    check("post_rst_out_k16", out_k16 === 4'd0, 64'(out_k16), 64'h0);
    check("post_rst_in_ready16", in_ready16 === 1'b1, 64'(in_ready16), 64'h1);
    check("post_rst_out_valid2k", out_valid2k === 1'b0, 64'(out_valid2k), 64'h0);
    check("post_rst_out_bits2k", out_bits2k === {2048{1'b0}}, out_bits2k[0:63], 64'h0);
    check("post_rst_in_ready2k", in_ready2k === 1'b1, 64'(in_ready2k), 64'h1);
    @(posedge clk); #1;

    // Single word, exact latency.
    send16(dir_b[0], dir_k[0], dir_e[0], 1'b1, w);
    drain16();

    // Directed N=16 vectors, back to back.
    for (int i = 0; i < 5; i++) send16(dir_b[i], dir_k[i], dir_e[i], 1'b1, w);
    drain16();

    // 32-word stream with out_ready high: in_ready never drops.
    for (int i = 0; i < 32; i++) begin
      logic [0:15] b;
      b = 16'($urandom);
      send16(b, 4'(i % 16), ref16(b, i % 16), 1'b1, w);
      check("stream_in_ready", w == 0, 64'(w), 64'h0);
    end
    drain16();

    // Backpressure: 10 stalled cycles with in_valid held high.
    for (int i = 0; i < 8; i++) begin
      bp_b[i] = 16'($urandom);
      bp_k[i] = 4'($urandom_range(0, 15));
    end
    out_ready16 = 1'b0;
    acc = 0;
    hold_seen = 1'b0;
    hold_bits = 16'h0;
    hold_k = 4'd0;
    for (int c = 0; c < 10; c++) begin
      in_valid16 = 1'b1;
      in_bits16 = bp_b[acc];
      in_k16 = bp_k[acc];
      @(negedge clk);
      if (in_ready16 && acc < 7) begin
        e16_t e;
        e.bits = ref16(bp_b[acc], int'(bp_k[acc])); e.k = bp_k[acc];
        e.issue = cycle; e.lat = 1'b0;
        q16.push_back(e);
        acc++;
      end
      if (out_valid16) begin
        if (hold_seen) begin
          check("bp_hold_bits", out_bits16 === hold_bits, 64'(out_bits16), 64'(hold_bits));
          check("bp_hold_k", out_k16 === hold_k, 64'(out_k16), 64'(hold_k));
        end else begin
          hold_seen = 1'b1;
          hold_bits = out_bits16;
          hold_k = out_k16;
        end
      end
      @(posedge clk); #1;
    end
    check("bp_accepted", acc == LAT16, 64'(acc), 64'(LAT16));
    check("bp_out_valid_seen", hold_seen, 64'(hold_seen), 64'h1);
    @(negedge clk);
    check("bp_in_ready_low", in_ready16 === 1'b0, 64'(in_ready16), 64'h0);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    out_ready16 = 1'b1;
    drain16();

    // Reset mid-stream with 3 words in flight.
    for (int i = 0; i < 3; i++) send16(dir_b[i+1], dir_k[i+1], dir_e[i+1], 1'b0, w);
    rst16 = 1'b1;
    out_ready16 = 1'b0;
    in_valid16 = 1'b1; in_bits16 = 16'hFFFF; in_k16 = 4'd3;
    q16.delete();
    @(negedge clk);
    check("midrst_in_ready", in_ready16 === 1'b0, 64'(in_ready16), 64'h0);
    @(posedge clk); #1;
    rst16 = 1'b0;
    in_valid16 = 1'b0;
    out_ready16 = 1'b1;
    outs_before = cnt_out16;
    @(negedge clk);
    check("midrst_out_valid", out_valid16 === 1'b0, 64'(out_valid16), 64'h0);
    check("midrst_out_bits", out_bits16 === 16'h0, 64'(out_bits16), 64'h0);
    check("midrst_out_k", out_k16 === 4'd0, 64'(out_k16), 64'h0);
    check("midrst_in_ready", in_ready16 === 1'b1, 64'(in_ready16), 64'h1);
    repeat (20) @(negedge clk);
    check("midrst_no_ghost", cnt_out16 == outs_before, 64'(cnt_out16), 64'(outs_before));
    @(posedge clk); #1;

    // N=2048 boundary amounts with hand-formed expectations.
    wd = rand_word();
    send2k(wd, 11'd0, wd, 1'b1);
    wd = rand_word();
    send2k(wd, 11'd1, {wd[1:2047], wd[0]}, 1'b1);
    wd = rand_word();
    send2k(wd, 11'd1024, {wd[1024:2047], wd[0:1023]}, 1'b1);
    wd = rand_word();
    send2k(wd, 11'd2047, {wd[2047], wd[0:2046]}, 1'b1);
    drain2k();

    // Random amounts against the reference rotator.
    for (int i = 0; i < 4; i++) begin
      wd = rand_word();
      kd = 11'($urandom_range(0, 2047));
      send2k(wd, kd, rotl(wd, int'(kd)), 1'b1);
    end
    drain2k();

    // Round trip through the upstream right rotator.
    for (int i = 0; i < 6; i++) begin
      wd = rand_word();
      kd = 11'($urandom_range(0, 2047));
      send2k(rotr2k(wd, int'(kd)), kd, wd, 1'b1);
    end
    drain2k();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
